gf180mcu_fd_sc_mcu9t5v0__addn_pipe: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__addn_pipe.sv | 126 ++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__addn_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__addn_pipe.sv
// Pipelined WIDTH-bit ripple adder {CO,S} = A + B + CI, carry chain cut into STAGES registered segments.
// Latency STAGES cycles; READY_IN is a combinational ready chain and drops only when every stage is full.
// Defining ADDN_PIPE_OVF_EN adds the registered two's-complement overflow output OV.
module gf180mcu_fd_sc_mcu9t5v0__addn_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             VALID_IN,
    output logic             READY_IN,
    output logic [WIDTH-1:0] S,
    output logic             CO,
`ifdef ADDN_PIPE_OVF_EN
    output logic             OV,
`endif
    output logic             VALID_OUT,
    input  logic             READY_OUT,
    inout  wire              VDD,
    inout  wire              VSS
);
    localparam int SEG = WIDTH / STAGES;

    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic              r_c   [STAGES];
    logic [STAGES-1:0] r_vld;

    logic [WIDTH-1:0]  w_a     [STAGES];
    logic [WIDTH-1:0]  w_b     [STAGES];
    logic [WIDTH-1:0]  w_sum   [STAGES];
    logic              w_cin   [STAGES];
    logic [WIDTH-1:0]  w_nsum  [STAGES];
    logic              w_nc    [STAGES];
    logic [STAGES-1:0] w_in_vld;
    logic [STAGES-1:0] w_load;
    logic [STAGES:0]   w_rdy;
    logic [SEG:0]      w_seg;

    wire w_unused_rails = VDD ^ VSS;

    always_comb begin
        w_rdy = '0;
        // w_rdy[k]: stage k can take a new item (empty, or its occupant leaves this edge).
        w_rdy[STAGES] = READY_OUT;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_rdy[k] = !r_vld[k] || w_rdy[k+1];
        end

        w_in_vld[0] = VALID_IN;
        w_a[0]      = A;
        w_b[0]      = B;
        w_sum[0]    = '0;
        w_cin[0]    = CI;
        for (int k = 1; k < STAGES; k++) begin
            w_in_vld[k] = r_vld[k-1];
            w_a[k]      = r_a[k-1];
            w_b[k]      = r_b[k-1];
            w_sum[k]    = r_sum[k-1];
            w_cin[k]    = r_c[k-1];
        end

        w_seg = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_load[k] = w_in_vld[k] && w_rdy[k];
            w_seg = {1'b0, w_a[k][k*SEG +: SEG]} + {1'b0, w_b[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, w_cin[k]};
            w_nsum[k]              = w_sum[k];
            w_nsum[k][k*SEG +: SEG] = w_seg[SEG-1:0];
            w_nc[k]                = w_seg[SEG];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_vld[k] <= 1'b1;
                    r_a[k]   <= w_a[k];
                    r_b[k]   <= w_b[k];
                    r_sum[k] <= w_nsum[k];
                    r_c[k]   <= w_nc[k];
                end else if (w_rdy[k+1]) begin
                    r_vld[k] <= 1'b0;
                end
            end
        end
    end

`ifdef ADDN_PIPE_OVF_EN
    logic r_ov;
    logic w_ov;

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    assign w_ov = w_a[STAGES-1][WIDTH-1] ^ w_b[STAGES-1][WIDTH-1]
                ^ w_nsum[STAGES-1][WIDTH-1] ^ w_nc[STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ov <= 1'b0;
        end else if (w_load[STAGES-1]) begin
            r_ov <= w_ov;
        end
    end

    assign OV = r_ov;
`endif

    assign READY_IN  = w_rdy[0];
    assign S         = r_sum[STAGES-1];
    assign CO        = r_c[STAGES-1];
    assign VALID_OUT = r_vld[STAGES-1];

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__addn_pipe.sv
// Directed bench for the pipelined adder: reset, latency, streaming, backpressure, mid-flight reset,
// a multi-configuration random sweep, and OV when ADDN_PIPE_OVF_EN is defined.
module tb_gf180mcu_fd_sc_mcu9t5v0__addn_pipe;
    logic       clk = 1'b0;
    logic       rst, vin, rout, ci;
    logic [7:0] a, b;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    logic [7:0] s, s1, s4, s8;
    logic       sw;
    logic       co, co1, co4, co8, cow;
    logic       vout, vo1, vo4, vo8, vow;
    logic       rin, unused_ri1, unused_ri4, unused_ri8, unused_riw;
`ifdef ADDN_PIPE_OVF_EN
    logic       ov, unused_ov1, unused_ov4, unused_ov8, unused_ovw;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__addn_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
        .CLK(clk), .RST(rst), .A(a), .B(b), .CI(ci), .VALID_IN(vin), .READY_IN(rin),
        .S(s), .CO(co),
`ifdef ADDN_PIPE_OVF_EN
        .OV(ov),
`endif
        .VALID_OUT(vout), .READY_OUT(rout), .VDD(vdd), .VSS(vss));

    gf180mcu_fd_sc_mcu9t5v0__addn_pipe #(.WIDTH(8), .STAGES(1)) u_s1 (
        .CLK(clk), .RST(rst), .A(a), .B(b), .CI(ci), .VALID_IN(vin), .READY_IN(unused_ri1),
        .S(s1), .CO(co1),
`ifdef ADDN_PIPE_OVF_EN
        .OV(unused_ov1),
`endif
        .VALID_OUT(vo1), .READY_OUT(rout), .VDD(vdd), .VSS(vss));

    gf180mcu_fd_sc_mcu9t5v0__addn_pipe #(.WIDTH(8), .STAGES(4)) u_s4 (
        .CLK(clk), .RST(rst), .A(a), .B(b), .CI(ci), .VALID_IN(vin), .READY_IN(unused_ri4),
        .S(s4), .CO(co4),
`ifdef ADDN_PIPE_OVF_EN
        .OV(unused_ov4),
`endif
        .VALID_OUT(vo4), .READY_OUT(rout), .VDD(vdd), .VSS(vss));

    gf180mcu_fd_sc_mcu9t5v0__addn_pipe #(.WIDTH(8), .STAGES(8)) u_s8 (
        .CLK(clk), .RST(rst), .A(a), .B(b), .CI(ci), .VALID_IN(vin), .READY_IN(unused_ri8),
        .S(s8), .CO(co8),
`ifdef ADDN_PIPE_OVF_EN
        .OV(unused_ov8),
`endif
        .VALID_OUT(vo8), .READY_OUT(rout), .VDD(vdd), .VSS(vss));

    gf180mcu_fd_sc_mcu9t5v0__addn_pipe #(.WIDTH(1), .STAGES(1)) u_w1 (
        .CLK(clk), .RST(rst), .A(a[0]), .B(b[0]), .CI(ci), .VALID_IN(vin), .READY_IN(unused_riw),
        .S(sw), .CO(cow),
`ifdef ADDN_PIPE_OVF_EN
        .OV(unused_ovw),
`endif
        .VALID_OUT(vow), .READY_OUT(rout), .VDD(vdd), .VSS(vss));

    task automatic test_reset();
        rst = 1'b1; vin = 1'b0; rout = 1'b1; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests++; if (vout !== 1'b0) begin fails++; $display("FAIL reset_vout got=%b want=0", vout); end
        tests++; if (s !== 8'h00) begin fails++; $display("FAIL reset_s got=%h want=00", s); end
        tests++; if (co !== 1'b0) begin fails++; $display("FAIL reset_co got=%b want=0", co); end
        tests++; if (rin !== 1'b1) begin fails++; $display("FAIL reset_rdy got=%b want=1", rin); end

        a = 8'hFF; b = 8'h01; ci = 1'b0; vin = 1'b1;
        @(posedge clk);
        #1 vin = 1'b0;
        tests++; if (vout !== 1'b0) begin fails++; $display("FAIL lat_early got=%b want=0", vout); end
        @(posedge clk); #1;
        tests++;
        if (vout !== 1'b1 || s !== 8'h00 || co !== 1'b1) begin
            fails++; $display("FAIL lat_out vout=%b s=%h co=%b want 1/00/1", vout, s, co);
        end
        @(posedge clk); #1;
        tests++; if (vout !== 1'b0) begin fails++; $display("FAIL lat_pulse got=%b want=0", vout); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta[3], tb_[3], es[3];
        logic       tc[3], ec[3];
        int sent = 0, got = 0, first = -1, last = -1;
        ta = '{8'h10, 8'h80, 8'h0F}; tb_ = '{8'h20, 8'h80, 8'hF0}; tc = '{1'b0, 1'b1, 1'b1};
        es = '{8'h30, 8'h01, 8'h00}; ec = '{1'b0, 1'b1, 1'b1};
        for (int cyc = 0; cyc < 10; cyc++) begin
            rout = 1'b1;
            if (sent < 3) begin vin = 1'b1; a = ta[sent]; b = tb_[sent]; ci = tc[sent]; end
            else vin = 1'b0;
            #1;
            if (vin && rin) sent++;
            if (vout && rout) begin
                tests++;
                if (got >= 3) begin
                    fails++; $display("FAIL stream_extra s=%h co=%b want none", s, co);
                end else if (s !== es[got] || co !== ec[got]) begin
                    fails++; $display("FAIL stream_data idx=%0d s=%h co=%b want %h/%b", got, s, co, es[got], ec[got]);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
        end
        tests++; if (got !== 3) begin fails++; $display("FAIL stream_count got=%0d want=3", got); end
        tests++; if (last - first !== 2) begin fails++; $display("FAIL stream_gap span=%0d want=2", last - first); end
    endtask

    task automatic test_backpressure();
        logic [7:0] ta[3], tb_[3], es[3];
        logic       tc[3], ec[3];
        int sent = 0, got = 0;
        ta = '{8'h11, 8'hFF, 8'h01}; tb_ = '{8'h22, 8'hFF, 8'h02}; tc = '{1'b0, 1'b1, 1'b1};
        es = '{8'h33, 8'hFF, 8'h04}; ec = '{1'b0, 1'b1, 1'b0};
        for (int cyc = 0; cyc < 14; cyc++) begin
            rout = (cyc >= 6);
            if (sent < 3) begin vin = 1'b1; a = ta[sent]; b = tb_[sent]; ci = tc[sent]; end
            else vin = 1'b0;
            #1;
            if (cyc >= 2 && cyc <= 5) begin
                tests++;
                if (rin !== 1'b0 || vout !== 1'b1 || s !== es[0] || co !== ec[0]) begin
                    fails++;
                    $display("FAIL stall cyc=%0d rdy=%b vout=%b s=%h co=%b want 0/1/%h/%b",
                             cyc, rin, vout, s, co, es[0], ec[0]);
                end
            end
            if (vin && rin) sent++;
            if (vout && rout) begin
                tests++;
                if (got >= 3) begin
                    fails++; $display("FAIL bp_extra s=%h co=%b want none", s, co);
                end else if (s !== es[got] || co !== ec[got]) begin
                    fails++; $display("FAIL bp_data idx=%0d s=%h co=%b want %h/%b", got, s, co, es[got], ec[got]);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        tests++; if (sent !== 3) begin fails++; $display("FAIL bp_accepted got=%0d want=3", sent); end
        tests++; if (got !== 3) begin fails++; $display("FAIL bp_emitted got=%0d want=3", got); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        rout = 1'b0;
        a = 8'hAA; b = 8'h55; ci = 1'b0; vin = 1'b1;
        @(posedge clk); #1;
        a = 8'h12; b = 8'h34; ci = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; vin = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (vout !== 1'b0 || s !== 8'h00 || co !== 1'b0 || rin !== 1'b1) begin
            fails++; $display("FAIL midrst_state vout=%b s=%h co=%b rdy=%b want 0/00/0/1", vout, s, co, rin);
        end
        rout = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (vout) seen++;
            @(posedge clk); #1;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_leak got=%0d want=0", seen); end
    endtask

    task automatic test_sweep();
        logic [8:0] exp9, got[5];
        logic [1:0] exp2;
        int lat[5], want_lat[5];
        want_lat = '{2, 1, 4, 8, 1};
        rst = 1'b1; vin = 1'b0; rout = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom_range(0, 1)); vin = 1'b1;
            exp9 = {1'b0, a} + {1'b0, b} + {8'd0, ci};
            exp2 = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, ci};
            for (int i = 0; i < 5; i++) begin lat[i] = 0; got[i] = '0; end
            @(posedge clk);
            #1 vin = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                if (vout && lat[0] == 0) begin lat[0] = k; got[0] = {co, s}; end
                if (vo1 && lat[1] == 0) begin lat[1] = k; got[1] = {co1, s1}; end
                if (vo4 && lat[2] == 0) begin lat[2] = k; got[2] = {co4, s4}; end
                if (vo8 && lat[3] == 0) begin lat[3] = k; got[3] = {co8, s8}; end
                if (vow && lat[4] == 0) begin lat[4] = k; got[4] = {7'd0, cow, sw}; end
                @(posedge clk); #1;
            end
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (lat[i] != want_lat[i] || got[i] !== ((i == 4) ? {7'd0, exp2} : exp9)) begin
                    fails++;
                    $display("FAIL sweep cfg=%0d n=%0d lat=%0d sum=%h want lat=%0d sum=%h", i, n, lat[i],
                             got[i], want_lat[i], (i == 4) ? {7'd0, exp2} : exp9);
                end
            end
        end
    endtask

`ifdef ADDN_PIPE_OVF_EN
    task automatic test_ovf();
        logic [7:0] ta[3], tb_[3];
        logic       eo[3], ec[3];
        ta = '{8'h7F, 8'h80, 8'h05}; tb_ = '{8'h01, 8'hFF, 8'h03};
        eo = '{1'b1, 1'b1, 1'b0};    ec = '{1'b0, 1'b1, 1'b0};
        rout = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = ta[i]; b = tb_[i]; ci = 1'b0; vin = 1'b1;
            @(posedge clk);
            #1 vin = 1'b0;
            @(posedge clk); #1;
            tests++;
            if (vout !== 1'b1 || ov !== eo[i] || co !== ec[i]) begin
                fails++; $display("FAIL ovf idx=%0d vout=%b ov=%b co=%b want 1/%b/%b", i, vout, ov, co, eo[i], ec[i]);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef ADDN_PIPE_OVF_EN
        test_ovf();
`endif
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
